multi_player_game_fsm: RTL and testbench
========================================

MULTI_PLAYER_GAME_FSM -- requirements
Module: multi_player_game_fsm

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2: player count, legal range 1..4.
REQ-002 SHALL have parameter SCORE_W, default 6: per-player score width.
REQ-003 SHALL have parameter GAME_TIME, default 30: game length in seconds, minimum 1.
REQ-004 SHALL have parameter TICK_DIV, default 100_000_000: clkIn cycles per one-second tick, minimum 2.
REQ-005 SHALL derive TIME_W = clog2(GAME_TIME+1) and PIDX_W = max(1, clog2(NUM_PLAYERS)).
REQ-006 SHALL have port clkIn, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port startGame, input, 1 bit: start or restart request, one-cycle pulse.
REQ-009 SHALL have port pauseGame, input, 1 bit: pause/resume toggle, one-cycle pulse.
REQ-010 SHALL have port player_scored, input, NUM_PLAYERS bits: bit i high for one cycle awards player i one point.
REQ-011 SHALL have port timer_expired, input, 1 bit: external forced end of game.
REQ-012 SHALL have ports game_active, paused and game_over, output, 1 bit each: one-hot state indicators (PLAY, PAUSE, OVER).
REQ-013 SHALL have port time_left, output, TIME_W bits: seconds remaining.
REQ-014 SHALL have port score, output, NUM_PLAYERS*SCORE_W bits: player i occupies bits [i*SCORE_W +: SCORE_W].
REQ-015 SHALL have port leader, output, PIDX_W bits; port tie, output, 1 bit; port high_score, output, SCORE_W bits; port new_high, output, 1 bit.

Function
REQ-016 SHALL implement states IDLE, PLAY, PAUSE and OVER.
REQ-017 IDLE or OVER with startGame high SHALL go to PLAY next cycle, with all scores 0, time_left=GAME_TIME, prescaler 0 and new_high 0.
REQ-018 startGame SHALL be ignored in PLAY and PAUSE.
REQ-019 PLAY with pauseGame SHALL go to PAUSE; PAUSE with pauseGame SHALL go to PLAY; pauseGame SHALL be ignored in IDLE and OVER.
REQ-020 The prescaler SHALL count only in PLAY, hold its value in PAUSE, and on reaching TICK_DIV-1 wrap to 0 and emit one internal tick.
REQ-021 Each tick in PLAY SHALL decrement time_left; a tick with time_left==1 SHALL set time_left=0 and enter OVER in the same cycle.
REQ-022 timer_expired in PLAY or PAUSE SHALL enter OVER next cycle with time_left holding its current value.
REQ-023 If timer_expired and pauseGame are asserted together, timer_expired SHALL win.
REQ-024 In PLAY, every set bit of player_scored SHALL increment that player's score, and simultaneous bits SHALL all count.
REQ-025 Each score SHALL saturate at 2^SCORE_W-1 and never wrap.
REQ-026 Scores SHALL be ignored in IDLE, PAUSE and OVER.
REQ-027 A score pulse in the same cycle as the final tick or timer_expired SHALL still be counted.
REQ-028 leader SHALL be combinational from the score registers: index of the maximum score, lowest index on equality.
REQ-029 tie SHALL be 1 when two or more players share a nonzero maximum, and 0 when NUM_PLAYERS==1.
REQ-030 On entry to OVER, if the maximum score (including any same-cycle point) exceeds high_score, high_score SHALL take that value and new_high SHALL assert.
REQ-031 new_high SHALL stay asserted until the next entry to PLAY.
REQ-032 In OVER, scores, time_left and leader SHALL hold.

Reset
REQ-033 Reset low SHALL immediately force state IDLE, scores 0, time_left=GAME_TIME, prescaler 0, high_score 0 and new_high 0.
REQ-034 Outputs during reset SHALL be game_active=0, paused=0, game_over=0, leader=0 and tie=0.
REQ-035 Reset asserted mid-game SHALL abort to IDLE and clear high_score.
REQ-036 After reset deasserts, the first startGame edge SHALL be honoured.

Structure
REQ-037 The state encoding and the per-player score-slice helper SHALL live in shared package game_pkg.
REQ-038 The prescaler SHALL be a sub-module, tick_prescaler (parameter TICK_DIV; inputs clkIn, reset, en, clr; output tick).
REQ-039 The FSM, score bank and leader/high-score logic SHALL reside in multi_player_game_fsm.

Verification (GAME_TIME=3, TICK_DIV=4, NUM_PLAYERS=2, SCORE_W=3)
REQ-040 Normal game: startGame, then no input -> time_left steps 3,2,1,0 at 4-cycle intervals; game_over is 1 at cycle 12 after PLAY entry.
REQ-041 Scoring: p0 scores 2, p1 scores 1, including one simultaneous 2'b11 pulse -> score p0=2, p1=1, leader=0, tie=0; at OVER high_score=2 and new_high=1.
REQ-042 Saturation and tie: 9 pulses to each player -> both scores 7, tie=1, leader=0.
REQ-043 Pause: pause at time_left=2 for 20 cycles, then resume -> time_left frozen at 2, scores ignored while paused, remaining ticks resume from the held prescaler value.
REQ-044 Overrides: timer_expired with pauseGame in PLAY -> OVER; then startGame -> PLAY with scores 0; a second game with max 1 -> high_score stays 2, new_high=0.
REQ-045 Async reset mid-PLAY, between clock edges -> all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the multi-player game controller: the FSM state
// encoding and the helper that locates a player's slice in the score bus.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  // Low bit of player idx inside a flat score bus of score_w-bit fields
  function automatic int score_lo(input int idx, input int score_w);
    return idx * score_w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator: counts enabled cycles and pulses tick as the
// count wraps from TICK_DIV-1 back to 0; clr restarts the count.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clkIn,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = en && !clr && (cnt_reg == CNT_LAST);

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_player_game_fsm.sv
// Game controller: IDLE/PLAY/PAUSE/OVER FSM with countdown timer, saturating
// per-player score bank, leader/tie detection and a persistent high score.
module multi_player_game_fsm
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 6,
  parameter int GAME_TIME   = 30,
  parameter int TICK_DIV    = 100_000_000,
  localparam int TIME_W     = $clog2(GAME_TIME + 1),
  localparam int PIDX_W     = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clkIn,
  input  logic                           reset,
  input  logic                           startGame,
  input  logic                           pauseGame,
  input  logic [NUM_PLAYERS-1:0]         player_scored,
  input  logic                           timer_expired,
  output logic                           game_active,
  output logic                           paused,
  output logic                           game_over,
  output logic [TIME_W-1:0]              time_left,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [PIDX_W-1:0]              leader,
  output logic                           tie,
  output logic [SCORE_W-1:0]             high_score,
  output logic                           new_high
);

  localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(GAME_TIME);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_t state_reg, state_next;
  logic [TIME_W-1:0]  time_left_reg, time_left_next;
  logic [SCORE_W-1:0] high_score_reg, high_score_next;
  logic               new_high_reg, new_high_next;
  logic               tick, start_req, presc_en;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] lead_max;
  logic [2:0]         n_top;

  function automatic logic [SCORE_W-1:0] max_of(input logic [NUM_PLAYERS-1:0][SCORE_W-1:0] v);
    logic [SCORE_W-1:0] m;
    m = v[0];
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (v[i] > m) m = v[i];
    end
    return m;
  endfunction

  assign start_req = startGame && ((state_reg == ST_IDLE) || (state_reg == ST_OVER));
  assign presc_en  = (state_reg == ST_PLAY);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clkIn (clkIn),
    .reset (reset),
    .en    (presc_en),
    .clr   (start_req),
    .tick  (tick)
  );

  // One saturating counter per player; points only land while in PLAY
  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score
    logic [SCORE_W-1:0] s_reg, s_next;

    always_comb begin
      s_next = s_reg;
      if (start_req) begin
        s_next = '0;
      end else if ((state_reg == ST_PLAY) && player_scored[gi] && (s_reg != SCORE_MAX)) begin
        s_next = s_reg + SCORE_W'(1);
      end
    end

    always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) s_reg <= '0;
      else        s_reg <= s_next;
    end

    assign score_q[gi] = s_reg;
    assign score_d[gi] = s_next;
    assign score[score_lo(gi, SCORE_W) +: SCORE_W] = s_reg;
  end

  always_comb begin
    lead_max = score_q[0];
    leader   = '0;
    n_top    = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (score_q[i] > lead_max) begin
        lead_max = score_q[i];
        leader   = PIDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (score_q[i] == lead_max) n_top = n_top + 3'd1;
    end
    tie = (n_top >= 3'd2) && (lead_max != '0);
  end

  always_comb begin
    state_next      = state_reg;
    time_left_next  = time_left_reg;
    high_score_next = high_score_reg;
    new_high_next   = new_high_reg;
    case (state_reg)
      ST_IDLE, ST_OVER: begin
        if (startGame) begin
          state_next     = ST_PLAY;
          time_left_next = TIME_INIT;
          new_high_next  = 1'b0;
        end
      end
      ST_PLAY: begin
        // A forced end freezes the timer even if a tick lands in the same cycle
        if (timer_expired) begin
          state_next = ST_OVER;
        end else begin
          if (tick) time_left_next = time_left_reg - TIME_W'(1);
          if (tick && (time_left_reg == TIME_W'(1))) state_next = ST_OVER;
          else if (pauseGame)                        state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (timer_expired)  state_next = ST_OVER;
        else if (pauseGame) state_next = ST_PLAY;
      end
      default: state_next = ST_IDLE;
    endcase
    // Judge the high score on the post-update scores so last-cycle points count
    if ((state_next == ST_OVER) && (state_reg != ST_OVER) && (max_of(score_d) > high_score_reg)) begin
      high_score_next = max_of(score_d);
      new_high_next   = 1'b1;
    end
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      time_left_reg  <= TIME_INIT;
      high_score_reg <= '0;
      new_high_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      time_left_reg  <= time_left_next;
      high_score_reg <= high_score_next;
      new_high_reg   <= new_high_next;
    end
  end

  assign game_active = (state_reg == ST_PLAY);
  assign paused      = (state_reg == ST_PAUSE);
  assign game_over   = (state_reg == ST_OVER);
  assign time_left   = time_left_reg;
  assign high_score  = high_score_reg;
  assign new_high    = new_high_reg;

endmodule

// File: tb/tb_multi_player_game_fsm.sv
// Directed bench for multi_player_game_fsm with GAME_TIME=3, TICK_DIV=4,
// two players and 3-bit scores; expected values are hand-computed.
module tb_multi_player_game_fsm;

  logic       clkIn = 1'b0;
  logic       reset;
  logic       startGame, pauseGame, timer_expired;
  logic [1:0] player_scored;
  logic       game_active, paused, game_over, tie, new_high;
  logic [1:0] time_left;
  logic [5:0] score;
  logic [0:0] leader;
  logic [2:0] high_score;

  int checks   = 0;
  int failures = 0;

  multi_player_game_fsm #(
    .NUM_PLAYERS (2),
    .SCORE_W     (3),
    .GAME_TIME   (3),
    .TICK_DIV    (4)
  ) dut (
    .clkIn         (clkIn),
    .reset         (reset),
    .startGame     (startGame),
    .pauseGame     (pauseGame),
    .player_scored (player_scored),
    .timer_expired (timer_expired),
    .game_active   (game_active),
    .paused        (paused),
    .game_over     (game_over),
    .time_left     (time_left),
    .score         (score),
    .leader        (leader),
    .tie           (tie),
    .high_score    (high_score),
    .new_high      (new_high)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clkIn);
      #1;
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic [1:0] sc, input logic te);
    startGame     = s;
    pauseGame     = p;
    player_scored = sc;
    timer_expired = te;
    step(1);
    startGame     = 1'b0;
    pauseGame     = 1'b0;
    player_scored = 2'b00;
    timer_expired = 1'b0;
  endtask

  task automatic wait_over(input int bound);
    int n = 0;
    while (!game_over && n < bound) begin
      step(1);
      n++;
    end
    check("wait_over", 32'(game_over), 1);
  endtask

  initial begin
    reset         = 1'b0;
    startGame     = 1'b0;
    pauseGame     = 1'b0;
    player_scored = 2'b00;
    timer_expired = 1'b0;
    #12;
    check("rst_active", 32'(game_active), 0);
    check("rst_paused", 32'(paused), 0);
    check("rst_over",   32'(game_over), 0);
    check("rst_time",   32'(time_left), 3);
    check("rst_leader", 32'(leader), 0);
    check("rst_tie",    32'(tie), 0);
    @(posedge clkIn);
    #1;
    reset = 1'b1;
    step(2);
    check("idle_active", 32'(game_active), 0);

    // Normal countdown: 3,2,1,0 at 4-cycle intervals
    drive(1, 0, 2'b00, 0);
    check("n_active", 32'(game_active), 1);
    check("n_t3",     32'(time_left), 3);
    step(3);
    check("n_t3_hold", 32'(time_left), 3);
    step(1);
    check("n_t2", 32'(time_left), 2);
    step(4);
    check("n_t1", 32'(time_left), 1);
    step(3);
    check("n_not_over", 32'(game_over), 0);
    step(1);
    check("n_t0",      32'(time_left), 0);
    check("n_over",    32'(game_over), 1);
    check("n_active0", 32'(game_active), 0);
    check("n_newhigh", 32'(new_high), 0);

    // Scoring, with a point landing on the final tick
    drive(1, 0, 2'b00, 0);
    check("s_score0", 32'(score), 0);
    drive(0, 0, 2'b01, 0);
    check("s_score1", 32'(score), 1);
    step(10);
    check("s_t1", 32'(time_left), 1);
    drive(0, 0, 2'b11, 0);
    check("s_over",   32'(game_over), 1);
    check("s_score",  32'(score), 6'b001_010);
    check("s_leader", 32'(leader), 0);
    check("s_tie",    32'(tie), 0);
    check("s_high",   32'(high_score), 2);
    check("s_newhi",  32'(new_high), 1);
    step(3);
    check("s_hold_score", 32'(score), 6'b001_010);
    check("s_hold_time",  32'(time_left), 0);

    // Pause freezes timer, prescaler and scoring
    drive(1, 0, 2'b00, 0);
    check("p_newhi_clr", 32'(new_high), 0);
    step(4);
    check("p_t2", 32'(time_left), 2);
    drive(0, 1, 2'b00, 0);
    check("p_paused", 32'(paused), 1);
    check("p_active", 32'(game_active), 0);
    player_scored = 2'b11;
    step(5);
    player_scored = 2'b00;
    step(15);
    check("p_time_frozen", 32'(time_left), 2);
    check("p_score_ign",   32'(score), 0);
    drive(0, 1, 2'b00, 0);
    check("p_resumed", 32'(game_active), 1);
    step(2);
    check("p_t2_after", 32'(time_left), 2);
    step(1);
    check("p_t1", 32'(time_left), 1);
    step(4);
    check("p_over",  32'(game_over), 1);
    check("p_high",  32'(high_score), 2);
    check("p_newhi", 32'(new_high), 0);

    // Overrides: timer_expired beats pauseGame; start ignored mid-game
    drive(1, 0, 2'b00, 0);
    drive(0, 0, 2'b10, 0);
    check("o_score",  32'(score), 6'b001_000);
    check("o_leader", 32'(leader), 1);
    drive(0, 1, 2'b00, 1);
    check("o_over",   32'(game_over), 1);
    check("o_paused", 32'(paused), 0);
    check("o_time",   32'(time_left), 3);
    check("o_high",   32'(high_score), 2);
    check("o_newhi",  32'(new_high), 0);
    drive(0, 1, 2'b00, 0);
    check("o_pause_ign", 32'(game_over), 1);
    drive(0, 0, 2'b01, 0);
    check("o_score_ign", 32'(score), 6'b001_000);
    drive(1, 0, 2'b00, 0);
    check("o_restart", 32'(game_active), 1);
    check("o_clr",     32'(score), 0);
    check("o_t3",      32'(time_left), 3);
    step(3);
    drive(1, 0, 2'b00, 0);
    check("o_start_ign", 32'(time_left), 2);
    check("o_still_act", 32'(game_active), 1);
    drive(0, 1, 2'b00, 0);
    check("o_paused2", 32'(paused), 1);
    drive(0, 0, 2'b00, 1);
    check("o_over2", 32'(game_over), 1);
    check("o_time2", 32'(time_left), 2);

    // Saturation and tie
    drive(1, 0, 2'b00, 0);
    player_scored = 2'b11;
    step(9);
    player_scored = 2'b00;
    check("t_score",  32'(score), 6'b111_111);
    check("t_tie",    32'(tie), 1);
    check("t_leader", 32'(leader), 0);
    wait_over(20);
    check("t_high",  32'(high_score), 7);
    check("t_newhi", 32'(new_high), 1);

    // Asynchronous reset between edges mid-game
    drive(1, 0, 2'b00, 0);
    drive(0, 0, 2'b01, 0);
    step(4);
    #3;
    reset = 1'b0;
    #1;
    check("r_active", 32'(game_active), 0);
    check("r_over",   32'(game_over), 0);
    check("r_time",   32'(time_left), 3);
    check("r_score",  32'(score), 0);
    check("r_high",   32'(high_score), 0);
    check("r_newhi",  32'(new_high), 0);
    check("r_leader", 32'(leader), 0);
    @(posedge clkIn);
    #1;
    reset = 1'b1;
    drive(1, 0, 2'b00, 0);
    check("r_first_start", 32'(game_active), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
